// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave with a byte-wide register file, oversampled entirely in the clk_i domain.
// Optional `SPI_SLV_WR_PROTECT_EN: reg[NREGS-1] bit0 locks writes to all other registers.
module spi_slave_regs #(
    parameter int          NREGS       = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  ID_BYTE     = 8'h5A,
    localparam int         ADDR_W      = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                spi_sck_i,
    input  logic                spi_spisel_i,
    input  logic                spi_mosi_i,
    output logic                spi_miso_o,
    output logic                spi_misooen_o,
    output logic [NREGS*8-1:0]  regs_o,
    output logic                wr_strobe_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [7:0]          wr_data_o,
    output logic                rd_strobe_o,
    output logic                frame_err_o
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                  r_state, w_state_next;
    logic [SYNC_STAGES-1:0]  r_sck_sync, r_sel_sync, r_mosi_sync;
    logic                    r_sck_d, r_sel_d;
    logic [2:0]              r_bitcnt;
    logic [6:0]              r_rx;
    logic [7:0]              r_tx;
    logic                    r_rw, r_load_pend;
    logic [ADDR_W-1:0]       r_addr;
    logic [7:0]              r_regs [NREGS];
    logic                    r_wr_strobe, r_rd_strobe, r_frame_err;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [7:0]              r_wr_data;

    logic w_sck, w_sel, w_mosi;
    logic w_sck_rise, w_sck_fall, w_sel_rise, w_sel_fall;
    logic [7:0] w_byte;
    logic w_byte_done, w_wr_ok;

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_sel      = r_sel_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_sel_rise = w_sel & ~r_sel_d;
    assign w_sel_fall = ~w_sel & r_sel_d;
    assign w_byte     = {r_rx, w_mosi};
    assign w_byte_done = (r_state != IDLE) && !w_sel_rise && w_sck_rise && (r_bitcnt == 3'd7);

`ifdef SPI_SLV_WR_PROTECT_EN
    assign w_wr_ok = (r_addr == ADDR_W'(NREGS-1)) || !r_regs[NREGS-1][0];
`else
    assign w_wr_ok = 1'b1;
`endif

    // Select is released on the very clk its rise is seen, before the state register follows.
    assign spi_misooen_o = (r_state == IDLE) || w_sel_rise;
    assign spi_miso_o    = r_tx[7];
    assign wr_strobe_o   = r_wr_strobe;
    assign wr_addr_o     = r_wr_addr;
    assign wr_data_o     = r_wr_data;
    assign rd_strobe_o   = r_rd_strobe;
    assign frame_err_o   = r_frame_err;

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < NREGS; k++) regs_o[8*k +: 8] = r_regs[k];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sck_sync  <= '0;
            r_sel_sync  <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_sel_d     <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            r_sel_sync  <= {r_sel_sync[SYNC_STAGES-2:0], spi_spisel_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            r_sck_d     <= w_sck;
            r_sel_d     <= w_sel;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_sel_fall) w_state_next = CMD;
            CMD:     if (w_sel_rise) w_state_next = IDLE;
                     else if (w_byte_done) w_state_next = DATA;
            DATA:    if (w_sel_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_bitcnt    <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_rw        <= 1'b0;
            r_load_pend <= 1'b0;
            r_addr      <= '0;
            r_wr_strobe <= 1'b0;
            r_rd_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_rd_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state == IDLE) begin
                if (w_sel_fall) begin
                    r_tx        <= ID_BYTE;
                    r_bitcnt    <= '0;
                    r_load_pend <= 1'b0;
                end
            end else if (w_sel_rise) begin
                r_frame_err <= (r_bitcnt != 3'd0);
                r_load_pend <= 1'b0;
            end else if (w_sck_rise) begin
                r_rx     <= w_byte[6:0];
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    if (r_state == CMD) begin
                        r_rw        <= w_byte[7];
                        r_addr      <= w_byte[ADDR_W-1:0];
                        r_load_pend <= w_byte[7];
                    end else if (r_rw) begin
                        r_addr      <= r_addr + 1'b1;
                        r_load_pend <= 1'b1;
                    end else begin
                        if (w_wr_ok) begin
                            r_regs[r_addr] <= w_byte;
                            r_wr_strobe    <= 1'b1;
                            r_wr_addr      <= r_addr;
                            r_wr_data      <= w_byte;
                        end
                        r_addr <= r_addr + 1'b1;
                    end
                end
            end else if (w_sck_fall) begin
                // A pending read replaces the shift; write frames drain zeros out of the shifter.
                if (r_load_pend) begin
                    r_tx        <= r_regs[r_addr];
                    r_rd_strobe <= 1'b1;
                    r_load_pend <= 1'b0;
                end else begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs (NREGS=16): scoreboard queues for writes and MISO bytes.
// Build with +define+SPI_SLV_WR_PROTECT_EN to exercise the write-lock variant.
module tb_spi_slave_regs;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          sck = 1'b0;
    logic          spisel = 1'b1;
    logic          mosi = 1'b0;
    logic          miso, misooen;
    logic [127:0]  regs;
    logic          wrStrobe, rdStrobe, frameErr;
    logic [3:0]    wrAddr;
    logic [7:0]    wrData;

    int checks = 0;
    int failures = 0;
    int rdCnt = 0;
    int errCnt = 0;
    logic prevOen = 1'b1;
    logic [11:0] wrQ[$];
    logic [7:0]  misoQ[$];

    spi_slave_regs #(.NREGS(16), .SYNC_STAGES(2), .ID_BYTE(8'h5A)) dut (
        .clk_i(clk), .rstn_i(rstn), .spi_sck_i(sck), .spi_spisel_i(spisel),
        .spi_mosi_i(mosi), .spi_miso_o(miso), .spi_misooen_o(misooen),
        .regs_o(regs), .wr_strobe_o(wrStrobe), .wr_addr_o(wrAddr),
        .wr_data_o(wrData), .rd_strobe_o(rdStrobe), .frame_err_o(frameErr)
    );

    always #5 clk = ~clk;

    // Strobe monitor: pops the write scoreboard, counts read loads and frame errors.
    always @(negedge clk) begin
        if (rstn) begin
            if (wrStrobe) begin
                checks++;
                if (wrQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_wr got addr=%0h data=%02h expected no write", wrAddr, wrData);
                end else begin
                    logic [11:0] e;
                    e = wrQ.pop_front();
                    if ({wrAddr, wrData} !== e) begin
                        failures++;
                        $display("[TB] FAIL wr_strobe got %03h expected %03h", {wrAddr, wrData}, e);
                    end
                end
            end
            if (rdStrobe) rdCnt++;
            if (frameErr) begin
                errCnt++;
                checks++;
                if (prevOen !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL oen_at_sel_rise got %b expected 1", prevOen);
                end
            end
        end
        prevOen = misooen;
    end

    function automatic logic [7:0] regAt(input int k);
        return regs[8*k +: 8];
    endfunction

    task automatic spiStart();
        @(posedge clk);
        sck = 1'b0;
        spisel = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic spiEnd();
        @(posedge clk);
        spisel = 1'b1;
        repeat (6) @(posedge clk);
        sck = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    // Shifts nbits MSB-first; sck falls at the start of each bit and stays high after the last one.
    task automatic spiBits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (sck) begin
                @(posedge clk);
                sck = 1'b0;
            end
            mosi = tx[i];
            repeat (6) @(posedge clk);
            @(negedge clk);
            rx[i] = miso;
            @(posedge clk);
            sck = 1'b1;
            repeat (6) @(posedge clk);
        end
    endtask

    task automatic spiFrame(input logic [7:0] bytes[$]);
        logic [7:0] rx, e;
        spiStart();
        foreach (bytes[i]) begin
            spiBits(bytes[i], 8, rx);
            e = misoQ.pop_front();
            checks++;
            if (rx !== e) begin
                failures++;
                $display("[TB] FAIL miso_byte%0d got %02h expected %02h", i, rx, e);
            end
        end
        spiEnd();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({miso, misooen, wrStrobe, rdStrobe, frameErr} !== 5'b01000) begin
            failures++;
            $display("[TB] FAIL reset_outputs got %b expected 01000", {miso, misooen, wrStrobe, rdStrobe, frameErr});
        end
        checks++;
        if (regs !== '0) begin
            failures++;
            $display("[TB] FAIL reset_regs got %032h expected 0", regs);
        end
        @(posedge clk);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_write();
        wrQ.push_back({4'h3, 8'hAB});
        wrQ.push_back({4'h4, 8'hCD});
        misoQ = '{8'h5A, 8'h00, 8'h00};
        spiFrame('{8'h03, 8'hAB, 8'hCD});
        checks++;
        if ({regAt(3), regAt(4)} !== 16'hABCD) begin
            failures++;
            $display("[TB] FAIL write_regs got %04h expected ABCD", {regAt(3), regAt(4)});
        end
        checks++;
        if (wrQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL write_strobes got %0d missing expected 0", wrQ.size());
        end
    endtask

    task automatic test_read();
        rdCnt = 0;
        misoQ = '{8'h5A, 8'hAB, 8'hCD};
        spiFrame('{8'h83, 8'h00, 8'h00});
        checks++;
        if (rdCnt != 2) begin
            failures++;
            $display("[TB] FAIL read_strobes got %0d expected 2", rdCnt);
        end
    endtask

    task automatic test_wrap();
        wrQ.push_back({4'hF, 8'h11});
        wrQ.push_back({4'h0, 8'h22});
        wrQ.push_back({4'h1, 8'h33});
        misoQ = '{8'h5A, 8'h00, 8'h00, 8'h00};
        spiFrame('{8'h0F, 8'h11, 8'h22, 8'h33});
        checks++;
        if ({regAt(15), regAt(0), regAt(1)} !== 24'h112233) begin
            failures++;
            $display("[TB] FAIL wrap_regs got %06h expected 112233", {regAt(15), regAt(0), regAt(1)});
        end
        checks++;
        if (wrQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL wrap_strobes got %0d missing expected 0", wrQ.size());
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] rx;
        errCnt = 0;
        spiStart();
        spiBits(8'h05, 8, rx);
        checks++;
        if (rx !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL err_cmd_miso got %02h expected 5A", rx);
        end
        spiBits(8'hF0, 4, rx);
        spiEnd();
        checks++;
        if (errCnt != 1) begin
            failures++;
            $display("[TB] FAIL frame_err_pulses got %0d expected 1", errCnt);
        end
        checks++;
        if (regAt(5) !== 8'h00) begin
            failures++;
            $display("[TB] FAIL partial_byte_reg5 got %02h expected 00", regAt(5));
        end
    endtask

    task automatic test_reset_midread();
        logic [7:0] rx;
        spiStart();
        spiBits(8'h83, 4, rx);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({miso, misooen} !== 2'b01 || regs !== '0) begin
            failures++;
            $display("[TB] FAIL midread_reset got miso/oen=%b regs=%032h expected 01 and 0", {miso, misooen}, regs);
        end
        spisel = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        repeat (3) @(posedge clk);
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        rdCnt = 0;
        misoQ = '{8'h5A, 8'h00};
        spiFrame('{8'h80, 8'h00});
        checks++;
        if (rdCnt != 1) begin
            failures++;
            $display("[TB] FAIL post_reset_read_strobes got %0d expected 1", rdCnt);
        end
    endtask

    task automatic test_wr_protect();
        wrQ.push_back({4'hF, 8'h01});
        misoQ = '{8'h5A, 8'h00};
        spiFrame('{8'h0F, 8'h01});
`ifdef SPI_SLV_WR_PROTECT_EN
        misoQ = '{8'h5A, 8'h00};
        spiFrame('{8'h02, 8'h77});
        checks++;
        if (regAt(2) !== 8'h00) begin
            failures++;
            $display("[TB] FAIL locked_reg2 got %02h expected 00", regAt(2));
        end
        wrQ.push_back({4'hF, 8'h00});
        misoQ = '{8'h5A, 8'h00};
        spiFrame('{8'h0F, 8'h00});
`endif
        wrQ.push_back({4'h2, 8'h77});
        misoQ = '{8'h5A, 8'h00};
        spiFrame('{8'h02, 8'h77});
        checks++;
        if (regAt(2) !== 8'h77) begin
            failures++;
            $display("[TB] FAIL unlocked_reg2 got %02h expected 77", regAt(2));
        end
        checks++;
        if (wrQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL protect_strobes got %0d missing expected 0", wrQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_frame_err();
        test_reset_midread();
        test_wr_protect();
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
